lsu_align: RTL and testbench

LSU_ALIGN -- requirements
Module: lsu_align

---
 rtl/lsu_align.sv | 180 ++++++++++++++++++
 tb/tb_lsu_align.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align.sv
// Load/store alignment unit: maps byte/half/word/dword requests onto a word-wide memory port.
// Define LSU_MISALIGNED_SPLIT_EN to serve word-crossing accesses as two beats; otherwise they are rejected.
module lsu_align #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [2:0]              req_func,
  input  logic [31:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  output logic [31:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic [DATA_WIDTH-1:0]   mem_dout,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    resp_err
);

  localparam int B  = DATA_WIDTH / 8;
  localparam int OW = $clog2(B);
  localparam int SW = $clog2(DATA_WIDTH);
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, DONE, RESP} state_t;

  state_t          state_reg;
  logic [2:0]      func_reg;
  logic [OW-1:0]   off_reg;
  logic            we_reg;
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] beat0_reg;
  logic [B-1:0]          mask_hi_reg;
  logic                  split_reg;
`endif

  function automatic logic [3:0] size_of(input logic [2:0] f);
    case (f[1:0])
      2'd0:    return 4'd1;
      2'd1:    return 4'd2;
      2'd2:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Byte mask over two consecutive words; any bit in the upper word means the access splits.
  logic [OW-1:0]  req_off;
  logic [2*B-1:0] req_mask;
  logic           req_split;
  logic           req_illegal;

  always_comb begin
    req_off     = req_addr[OW-1:0];
    req_mask    = (2*B)'(((32'd1 << size_of(req_func)) - 32'd1) << req_off);
    req_split   = |req_mask[2*B-1:B];
    req_illegal = (req_func == 3'b111) || (req_we && req_func[2]) ||
                  (DATA_WIDTH == 32 && (req_func == 3'b011 || req_func == 3'b110));
  end

  logic [DATA_WIDTH-1:0] beat0;
  logic [DATA_WIDTH-1:0] beat1;
  logic [DATA_WIDTH-1:0] raw;
  logic [DATA_WIDTH-1:0] low_mask;
  logic [DATA_WIDTH-1:0] load_data;
  logic [3:0]            ld_size;
  logic [SW-1:0]         sign_idx;
  logic                  sign_ext;

  always_comb begin
`ifdef LSU_MISALIGNED_SPLIT_EN
    beat0 = split_reg ? beat0_reg : mem_dout;
`else
    beat0 = mem_dout;
`endif
    beat1     = mem_dout;
    raw       = DATA_WIDTH'({beat1, beat0} >> {off_reg, 3'b000});
    ld_size   = size_of(func_reg);
    low_mask  = ~({DATA_WIDTH{1'b1}} << {ld_size, 3'b000});
    sign_idx  = SW'({ld_size, 3'b000} - 7'd1);
    sign_ext  = !func_reg[2] && raw[sign_idx];
    load_data = (raw & low_mask) | (sign_ext ? ~low_mask : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      req_ready   <= 1'b1;
      mem_en      <= 1'b0;
      mem_we      <= '0;
      mem_addr    <= '0;
      mem_din     <= '0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_data   <= '0;
      func_reg    <= '0;
      off_reg     <= '0;
      we_reg      <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      wdata_reg   <= '0;
      beat0_reg   <= '0;
      mask_hi_reg <= '0;
      split_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            func_reg  <= req_func;
            off_reg   <= req_off;
            we_reg    <= req_we;
            req_ready <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            wdata_reg   <= req_wdata;
            mask_hi_reg <= req_mask[2*B-1:B];
            split_reg   <= req_split;
`endif
            if (req_illegal || (req_split && !SPLIT_EN)) begin
              state_reg  <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
            end else begin
              state_reg <= ACC0;
              mem_en    <= 1'b1;
              mem_addr  <= {req_addr[31:OW], {OW{1'b0}}};
              mem_we    <= req_we ? req_mask[B-1:0] : '0;
              mem_din   <= req_wdata << {req_off, 3'b000};
            end
          end
        end
        ACC0: begin
`ifdef LSU_MISALIGNED_SPLIT_EN
          if (split_reg) begin
            state_reg <= ACC1;
            mem_addr  <= mem_addr + 32'(B);
            mem_we    <= we_reg ? mask_hi_reg : '0;
            mem_din   <= wdata_reg >> (8 * (B - int'(off_reg)));
          end else
`endif
          begin
            state_reg <= DONE;
            mem_en    <= 1'b0;
            mem_we    <= '0;
          end
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        ACC1: begin
          beat0_reg <= mem_dout;
          mem_en    <= 1'b0;
          mem_we    <= '0;
          state_reg <= DONE;
        end
`endif
        DONE: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_data  <= we_reg ? '0 : load_data;
          state_reg  <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Scoreboard bench for lsu_align (32-bit build); expectations follow LSU_MISALIGNED_SPLIT_EN.
module tb_lsu_align;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_func = 3'b000;
  logic [31:0]   req_addr = 32'h0;
  logic [DW-1:0] req_wdata = '0;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          resp_err;

  lsu_align #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func(req_func), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_words [logic [31:0]];
  always @(posedge clk)
    if (mem_en && mem_we == 4'b0000)
      mem_dout <= mem_words.exists(mem_addr) ? mem_words[mem_addr] : 32'h0;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] cyc;
  } beat_t;
  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [31:0] cyc;
  } resp_t;

  beat_t obs_b[$];
  beat_t exp_b[$];
  resp_t obs_r[$];
  resp_t exp_r[$];
  beat_t eb, ob;
  resp_t er, orr;

  // Write data is only meaningful on store beats, so load beats record din as zero.
  always @(negedge clk) begin
    if (mem_en) obs_b.push_back({mem_addr, mem_we, (mem_we != 4'b0000) ? mem_din : 32'h0, 32'(cyc)});
    if (resp_valid) obs_r.push_back({resp_data, resp_err, 32'(cyc)});
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic we, input logic [2:0] func, input logic [31:0] addr,
                       input logic [31:0] wdata, output int acc);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_func  = func;
    req_addr  = addr;
    req_wdata = wdata;
    acc = -1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      @(posedge clk);
      if (req_ready) acc = cyc;
    end
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_func  = 3'b111;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept timed out addr=%h", addr);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 16 && obs_r.size() < exp_r.size(); i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b want 0", mem_en); end
    checks++; if (mem_we !== 4'b0000) begin errors++; $display("FAIL reset_mem_we got %b want 0000", mem_we); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
    checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data got %h want 0", resp_data); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("reset: released");
  endtask

  task automatic test_lw();
    int acc;
    issue(1'b0, 3'b010, 32'h100, 32'h0, acc);
    exp_b.push_back({32'h100, 4'b0000, 32'h0, 32'(acc + 1)});
    exp_r.push_back({32'hdeadbeef, 1'b0, 32'(acc + 3)});
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL lw_busy_ready got %b want 0", req_ready); end
    wait_idle();
    while (exp_b.size() > 0) begin
      eb = exp_b.pop_front();
      if (obs_b.size() > 0) ob = obs_b.pop_front(); else ob = '0;
      checks++; if (ob !== eb) begin errors++; $display("FAIL lw_beat got %h want %h", ob, eb); end
    end
    while (exp_r.size() > 0) begin
      er = exp_r.pop_front();
      if (obs_r.size() > 0) orr = obs_r.pop_front(); else orr = '0;
      checks++; if (orr !== er) begin errors++; $display("FAIL lw_resp got %h want %h", orr, er); end
    end
    checks++; if (obs_b.size() + obs_r.size() != 0) begin errors++; $display("FAIL lw_extra got %0d want 0", obs_b.size() + obs_r.size()); end
    $display("lw 0x100: done");
  endtask

  task automatic test_lb_lbu();
    int acc;
    issue(1'b0, 3'b000, 32'h103, 32'h0, acc);
    exp_b.push_back({32'h100, 4'b0000, 32'h0, 32'(acc + 1)});
    exp_r.push_back({32'hffffffde, 1'b0, 32'(acc + 3)});
    issue(1'b0, 3'b100, 32'h103, 32'h0, acc);
    exp_b.push_back({32'h100, 4'b0000, 32'h0, 32'(acc + 1)});
    exp_r.push_back({32'h000000de, 1'b0, 32'(acc + 3)});
    wait_idle();
    while (exp_b.size() > 0) begin
      eb = exp_b.pop_front();
      if (obs_b.size() > 0) ob = obs_b.pop_front(); else ob = '0;
      checks++; if (ob !== eb) begin errors++; $display("FAIL lb_beat got %h want %h", ob, eb); end
    end
    while (exp_r.size() > 0) begin
      er = exp_r.pop_front();
      if (obs_r.size() > 0) orr = obs_r.pop_front(); else orr = '0;
      checks++; if (orr !== er) begin errors++; $display("FAIL lb_resp got %h want %h", orr, er); end
    end
    checks++; if (obs_b.size() + obs_r.size() != 0) begin errors++; $display("FAIL lb_extra got %0d want 0", obs_b.size() + obs_r.size()); end
    $display("lb/lbu 0x103: done");
  endtask

  task automatic test_sh();
    int acc;
    issue(1'b1, 3'b001, 32'h102, 32'h0000abcd, acc);
    exp_b.push_back({32'h100, 4'b1100, 32'habcd0000, 32'(acc + 1)});
    exp_r.push_back({32'h0, 1'b0, 32'(acc + 3)});
    wait_idle();
    while (exp_b.size() > 0) begin
      eb = exp_b.pop_front();
      if (obs_b.size() > 0) ob = obs_b.pop_front(); else ob = '0;
      checks++; if (ob !== eb) begin errors++; $display("FAIL sh_beat got %h want %h", ob, eb); end
    end
    while (exp_r.size() > 0) begin
      er = exp_r.pop_front();
      if (obs_r.size() > 0) orr = obs_r.pop_front(); else orr = '0;
      checks++; if (orr !== er) begin errors++; $display("FAIL sh_resp got %h want %h", orr, er); end
    end
    checks++; if (obs_b.size() + obs_r.size() != 0) begin errors++; $display("FAIL sh_extra got %0d want 0", obs_b.size() + obs_r.size()); end
    $display("sh 0x102: done");
  endtask

  task automatic test_split();
    int acc;
    issue(1'b0, 3'b010, 32'h101, 32'h0, acc);
`ifdef LSU_MISALIGNED_SPLIT_EN
    exp_b.push_back({32'h100, 4'b0000, 32'h0, 32'(acc + 1)});
    exp_b.push_back({32'h104, 4'b0000, 32'h0, 32'(acc + 2)});
    exp_r.push_back({32'h44deadbe, 1'b0, 32'(acc + 4)});
`else
    exp_r.push_back({32'h0, 1'b1, 32'(acc + 1)});
`endif
    issue(1'b1, 3'b010, 32'hfffffffe, 32'ha1b2c3d4, acc);
`ifdef LSU_MISALIGNED_SPLIT_EN
    exp_b.push_back({32'hfffffffc, 4'b1100, 32'hc3d40000, 32'(acc + 1)});
    exp_b.push_back({32'h00000000, 4'b0011, 32'h0000a1b2, 32'(acc + 2)});
    exp_r.push_back({32'h0, 1'b0, 32'(acc + 4)});
`else
    exp_r.push_back({32'h0, 1'b1, 32'(acc + 1)});
`endif
    wait_idle();
    while (exp_b.size() > 0) begin
      eb = exp_b.pop_front();
      if (obs_b.size() > 0) ob = obs_b.pop_front(); else ob = '0;
      checks++; if (ob !== eb) begin errors++; $display("FAIL split_beat got %h want %h", ob, eb); end
    end
    while (exp_r.size() > 0) begin
      er = exp_r.pop_front();
      if (obs_r.size() > 0) orr = obs_r.pop_front(); else orr = '0;
      checks++; if (orr !== er) begin errors++; $display("FAIL split_resp got %h want %h", orr, er); end
    end
    checks++; if (obs_b.size() + obs_r.size() != 0) begin errors++; $display("FAIL split_extra got %0d want 0", obs_b.size() + obs_r.size()); end
    $display("split lw 0x101 / sw 0xfffffffe: done");
  endtask

  task automatic test_illegal();
    int acc;
    issue(1'b0, 3'b111, 32'h100, 32'h0, acc);
    exp_r.push_back({32'h0, 1'b1, 32'(acc + 1)});
    issue(1'b1, 3'b100, 32'h100, 32'h55, acc);
    exp_r.push_back({32'h0, 1'b1, 32'(acc + 1)});
    issue(1'b0, 3'b011, 32'h100, 32'h0, acc);
    exp_r.push_back({32'h0, 1'b1, 32'(acc + 1)});
    wait_idle();
    while (exp_r.size() > 0) begin
      er = exp_r.pop_front();
      if (obs_r.size() > 0) orr = obs_r.pop_front(); else orr = '0;
      checks++; if (orr !== er) begin errors++; $display("FAIL illegal_resp got %h want %h", orr, er); end
    end
    checks++; if (obs_b.size() + obs_r.size() != 0) begin errors++; $display("FAIL illegal_extra got %0d want 0", obs_b.size() + obs_r.size()); end
    $display("illegal funcs: done");
  endtask

  task automatic test_rst_mid();
    int acc;
`ifdef LSU_MISALIGNED_SPLIT_EN
    issue(1'b0, 3'b010, 32'h101, 32'h0, acc);
    @(posedge clk);
    #1;
`else
    issue(1'b0, 3'b010, 32'h100, 32'h0, acc);
`endif
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rst_pre_mem_en got %b want 1", mem_en); end
    rst = 1'b1;
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got %b want 0", mem_en); end
    checks++; if (mem_we !== 4'b0000) begin errors++; $display("FAIL rst_mem_we got %b want 0000", mem_we); end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (obs_r.size() != 0) begin errors++; $display("FAIL rst_no_resp got %0d want 0", obs_r.size()); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
    obs_b.delete();
    obs_r.delete();
    mem_words[32'h100] = 32'h00008001;
    issue(1'b0, 3'b001, 32'h100, 32'h0, acc);
    exp_b.push_back({32'h100, 4'b0000, 32'h0, 32'(acc + 1)});
    exp_r.push_back({32'hffff8001, 1'b0, 32'(acc + 3)});
    wait_idle();
    while (exp_b.size() > 0) begin
      eb = exp_b.pop_front();
      if (obs_b.size() > 0) ob = obs_b.pop_front(); else ob = '0;
      checks++; if (ob !== eb) begin errors++; $display("FAIL lh_beat got %h want %h", ob, eb); end
    end
    while (exp_r.size() > 0) begin
      er = exp_r.pop_front();
      if (obs_r.size() > 0) orr = obs_r.pop_front(); else orr = '0;
      checks++; if (orr !== er) begin errors++; $display("FAIL lh_resp got %h want %h", orr, er); end
    end
    mem_words[32'h100] = 32'hdeadbeef;
    $display("reset mid-transaction, then lh 0x100: done");
  endtask

  task automatic test_back_to_back();
    int acc;
    issue(1'b0, 3'b100, 32'h101, 32'h0, acc);
    exp_b.push_back({32'h100, 4'b0000, 32'h0, 32'(acc + 1)});
    exp_r.push_back({32'h000000be, 1'b0, 32'(acc + 3)});
    issue(1'b0, 3'b101, 32'h102, 32'h0, acc);
    exp_b.push_back({32'h100, 4'b0000, 32'h0, 32'(acc + 1)});
    exp_r.push_back({32'h0000dead, 1'b0, 32'(acc + 3)});
    issue(1'b1, 3'b000, 32'h107, 32'h0000005a, acc);
    exp_b.push_back({32'h104, 4'b1000, 32'h5a000000, 32'(acc + 1)});
    exp_r.push_back({32'h0, 1'b0, 32'(acc + 3)});
    wait_idle();
    while (exp_b.size() > 0) begin
      eb = exp_b.pop_front();
      if (obs_b.size() > 0) ob = obs_b.pop_front(); else ob = '0;
      checks++; if (ob !== eb) begin errors++; $display("FAIL b2b_beat got %h want %h", ob, eb); end
    end
    while (exp_r.size() > 0) begin
      er = exp_r.pop_front();
      if (obs_r.size() > 0) orr = obs_r.pop_front(); else orr = '0;
      checks++; if (orr !== er) begin errors++; $display("FAIL b2b_resp got %h want %h", orr, er); end
    end
    checks++; if (obs_b.size() + obs_r.size() != 0) begin errors++; $display("FAIL b2b_extra got %0d want 0", obs_b.size() + obs_r.size()); end
    $display("back-to-back lbu/lhu/sb: done");
  endtask

  initial begin
    mem_words[32'h100] = 32'hdeadbeef;
    mem_words[32'h104] = 32'h11223344;
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_split();
    test_illegal();
    test_rst_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
